// File: rtl/somador_serial_param_if.sv
// somador_serial_param_if: request/result bundle for the serial adder.
//   master (requester): drives start, a, b, cin (and sub when SOMADOR_SUB_EN
//                       is defined); observes busy, done, sum, carry_out, overflow.
//   slave  (adder)    : the mirror image.
// Optional feature macro: SOMADOR_SUB_EN adds the sub (subtract select) signal.
interface somador_serial_param_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SOMADOR_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

`ifdef SOMADOR_SUB_EN
  modport master (output start, a, b, cin, sub,
                  input  busy, done, sum, carry_out, overflow);
  modport slave  (input  start, a, b, cin, sub,
                  output busy, done, sum, carry_out, overflow);
`else
  modport master (output start, a, b, cin,
                  input  busy, done, sum, carry_out, overflow);
  modport slave  (input  start, a, b, cin,
                  output busy, done, sum, carry_out, overflow);
`endif
endinterface

// File: rtl/somador_serial_param.sv
// somador_serial_param: multi-cycle adder, CHUNK bits per clock, LSB chunk
// first, carry rippling between chunks through a carry register.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    somador_serial_param_if.slave:
//            start/a/b/cin(/sub) in, busy/done/sum/carry_out/overflow out
// Parameters: WIDTH (operand width, >= 1), CHUNK (bits per cycle, divides WIDTH).
// Optional feature macro: SOMADOR_SUB_EN -- sub=1 computes a - b as a + ~b + 1
// (latched cin ignored). Undefined: add only, no sub signal.
module somador_serial_param #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  somador_serial_param_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;     // holds b' (already inverted for subtraction)
  logic             carry_r;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             co_r;
  logic             ov_r;

  logic [WIDTH-1:0] b_in;
  logic             cin_in;

`ifdef SOMADOR_SUB_EN
  assign b_in   = bus.sub ? ~bus.b : bus.b;
  assign cin_in = bus.sub ? 1'b1   : bus.cin;
`else
  assign b_in   = bus.b;
  assign cin_in = bus.cin;
`endif

  // Current chunk sum and the accumulator as it will look after this edge;
  // the final edge copies acc_next straight into sum so the last chunk is
  // included without an extra cycle.
  int               idx;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK:0]   part;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    idx      = int'(cnt) * CHUNK;
    a_ch     = a_r[idx +: CHUNK];
    b_ch     = b_r[idx +: CHUNK];
    part     = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_r};
    acc_next = acc;
    acc_next[idx +: CHUNK] = part[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      co_r    <= 1'b0;
      ov_r    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= b_in;
            carry_r <= cin_in;
            acc     <= '0;
            cnt     <= '0;
            busy_r  <= 1'b1;
            state   <= RUN;
          end else begin
            state   <= IDLE;
          end
        end
        RUN: begin
          acc     <= acc_next;
          carry_r <= part[CHUNK];
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            sum_r  <= acc_next;
            co_r   <= part[CHUNK];
            ov_r   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                      (acc_next[WIDTH-1] != a_r[WIDTH-1]);
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = co_r;
  assign bus.overflow  = ov_r;
endmodule

// File: tb/tb_somador_serial_param.sv
// Bench for somador_serial_param: three instances (8/1, 8/4, 4/1) checked
// against an integer-arithmetic model of a + b' + cin'.
module tb_somador_serial_param;
`ifdef SOMADOR_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit toggle8 = 1'b0;
  logic [7:0] exp_sum8 = '0;

  somador_serial_param_if #(.WIDTH(8)) bus8 ();
  somador_serial_param_if #(.WIDTH(8)) bus84 ();
  somador_serial_param_if #(.WIDTH(4)) bus4 ();

  somador_serial_param #(.WIDTH(8), .CHUNK(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  somador_serial_param #(.WIDTH(8), .CHUNK(4)) dut84 (.clk(clk), .rst_n(rst_n), .bus(bus84));
  somador_serial_param #(.WIDTH(4), .CHUNK(1)) dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // Reference: exact integer sum, overflow from signed range check.
  function automatic void model(input int w, input longint a, input longint b,
                                input bit cin, input bit sub,
                                output longint s, output bit co, output bit ov);
    longint m, half, bp, cp, tot, as_v, bs_v, ss;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    bp   = sub ? (~b & m) : b;
    cp   = sub ? longint'(1) : longint'(cin);
    tot  = a + bp + cp;
    s    = tot & m;
    co   = ((tot >> w) & 1) != 0;
    as_v = (a  >= half) ? a  - 2 * half : a;
    bs_v = (bp >= half) ? bp - 2 * half : bp;
    ss   = as_v + bs_v + cp;
    ov   = (ss >= half) || (ss < -half);
  endfunction

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    bus8.a = a; bus8.b = b; bus8.cin = cin;
`ifdef SOMADOR_SUB_EN
    bus8.sub = sub;
`endif
    bus8.start = 1'b1;
  endtask

  // Counts edges after acceptance until done; while running, busy must be
  // high and sum must still show the previous result.
  task automatic wait_done8(output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (bus8.done === 1'b1) seen = 1'b1;
      else begin
        checks++;
        if (bus8.busy !== 1'b1) begin errors++; $display("FAIL busy_run got %b exp 1", bus8.busy); end
        checks++;
        if (bus8.sum !== exp_sum8) begin errors++; $display("FAIL sum_hold got %h exp %h", bus8.sum, exp_sum8); end
        if (toggle8) begin
          bus8.a = 8'($urandom); bus8.b = 8'($urandom);
          bus8.start = 1'($urandom_range(0, 1));
        end
      end
    end
    bus8.start = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL done_timeout8 got no done exp done within 40"); end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub, output int lat);
    @(negedge clk);
    drive8(a, b, cin, sub);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    if (toggle8) begin bus8.a = 8'($urandom); bus8.b = 8'($urandom); end
    wait_done8(lat);
  endtask

  task automatic op84(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub, output int lat);
    bit seen;
    @(negedge clk);
    bus84.a = a; bus84.b = b; bus84.cin = cin;
`ifdef SOMADOR_SUB_EN
    bus84.sub = sub;
`endif
    bus84.start = 1'b1;
    @(posedge clk); #1;
    bus84.start = 1'b0;
    seen = 1'b0; lat = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (bus84.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL done_timeout84 got no done exp done within 40"); end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic sub, output int lat);
    bit seen;
    @(negedge clk);
    bus4.a = a; bus4.b = b; bus4.cin = cin;
`ifdef SOMADOR_SUB_EN
    bus4.sub = sub;
`endif
    bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    seen = 1'b0; lat = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (bus4.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL done_timeout4 got no done exp done within 40"); end
  endtask

  task automatic test_reset();
    int done_seen;
    bus8.start = 0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 0;
    bus84.start = 0; bus84.a = '0; bus84.b = '0; bus84.cin = 0;
    bus4.start = 0;  bus4.a = '0;  bus4.b = '0;  bus4.cin = 0;
`ifdef SOMADOR_SUB_EN
    bus8.sub = 0; bus84.sub = 0; bus4.sub = 0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL idle_activity got %0d cycles busy/done exp 0", done_seen); end
    checks++;
    if (bus8.sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h exp 00", bus8.sum); end
    checks++;
    if ({bus8.carry_out, bus8.overflow} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got %b exp 00", {bus8.carry_out, bus8.overflow});
    end
    checks++;
    if ({bus84.busy, bus84.done, bus4.busy, bus4.done} !== 4'b0000 || bus84.sum !== 8'h00 || bus4.sum !== 4'h0) begin
      errors++; $display("FAIL reset_other got %b/%h/%h exp 0000/00/0",
                        {bus84.busy, bus84.done, bus4.busy, bus4.done}, bus84.sum, bus4.sum);
    end
  endtask

  task automatic test_directed();
    int lat;
    op8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
    checks++;
    if (lat != 8) begin errors++; $display("FAIL latency_ff01 got %0d exp 8", lat); end
    checks++;
    if ({bus8.carry_out, bus8.overflow, bus8.sum} !== {1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL ff01 got co=%b ov=%b sum=%h exp co=1 ov=0 sum=00", bus8.carry_out, bus8.overflow, bus8.sum);
    end
    checks++;
    if (bus8.busy !== 1'b0) begin errors++; $display("FAIL busy_in_done got %b exp 0", bus8.busy); end
    exp_sum8 = 8'h00;
    toggle8 = 1'b1;
    op8(8'h7F, 8'h01, 1'b1, 1'b0, lat);
    toggle8 = 1'b0;
    checks++;
    if ({bus8.carry_out, bus8.overflow, bus8.sum} !== {1'b0, 1'b1, 8'h81}) begin
      errors++; $display("FAIL 7f01c got co=%b ov=%b sum=%h exp co=0 ov=1 sum=81", bus8.carry_out, bus8.overflow, bus8.sum);
    end
    exp_sum8 = 8'h81;
    @(negedge clk);
    checks++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse got done=%b busy=%b exp 0 0", bus8.done, bus8.busy);
    end
    checks++;
    if (bus8.sum !== 8'h81) begin errors++; $display("FAIL sum_held got %h exp 81", bus8.sum); end
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] a, b;
    logic cin, sub;
    longint s;
    bit co, ov;
    toggle8 = 1'b1;
    for (int i = 0; i < 25; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = SUB_EN & 1'($urandom);
      model(8, a, b, cin, sub, s, co, ov);
      op8(a, b, cin, sub, lat);
      checks++;
      if (lat != 8 || bus8.sum !== 8'(s) || bus8.carry_out !== co || bus8.overflow !== ov) begin
        errors++;
        $display("FAIL rand8 a=%h b=%h cin=%b sub=%b got lat=%0d sum=%h co=%b ov=%b exp lat=8 sum=%h co=%b ov=%b",
                 a, b, cin, sub, lat, bus8.sum, bus8.carry_out, bus8.overflow, 8'(s), co, ov);
      end
      exp_sum8 = 8'(s);
    end
    toggle8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    op8(8'h3C, 8'h5A, 1'b0, 1'b0, lat);
    checks++;
    if (bus8.sum !== 8'h96) begin errors++; $display("FAIL b2b_first got %h exp 96", bus8.sum); end
    exp_sum8 = 8'h96;
    // Still in the done cycle: request the next operation immediately.
    drive8(8'h10, 8'h20, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    wait_done8(lat);
    checks++;
    if (lat != 8) begin errors++; $display("FAIL b2b_latency got %0d exp 8", lat); end
    checks++;
    if ({bus8.carry_out, bus8.overflow, bus8.sum} !== {1'b0, 1'b0, 8'h30}) begin
      errors++; $display("FAIL b2b_sum got co=%b ov=%b sum=%h exp co=0 ov=0 sum=30", bus8.carry_out, bus8.overflow, bus8.sum);
    end
    exp_sum8 = 8'h30;
  endtask

  task automatic test_reset_mid_run();
    int bad;
    @(negedge clk);
    drive8(8'hA5, 8'h3C, 1'b1, 1'b0);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.carry_out, bus8.overflow} !== 4'b0000 || bus8.sum !== 8'h00) begin
      errors++; $display("FAIL mid_reset got busy/done/co/ov=%b sum=%h exp 0000 00",
                        {bus8.busy, bus8.done, bus8.carry_out, bus8.overflow}, bus8.sum);
    end
    exp_sum8 = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || bus8.sum !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL post_reset_activity got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_chunk4();
    int lat;
    logic [7:0] a, b;
    logic cin, sub;
    longint s;
    bit co, ov;
    if (SUB_EN) begin
      op84(8'h05, 8'h07, 1'b0, 1'b1, lat);
      checks++;
      if (lat != 2 || {bus84.carry_out, bus84.overflow, bus84.sum} !== {1'b0, 1'b0, 8'hFE}) begin
        errors++; $display("FAIL sub84 got lat=%0d co=%b ov=%b sum=%h exp lat=2 co=0 ov=0 sum=FE",
                          lat, bus84.carry_out, bus84.overflow, bus84.sum);
      end
    end else begin
      op84(8'h05, 8'h07, 1'b0, 1'b0, lat);
      checks++;
      if (lat != 2 || {bus84.carry_out, bus84.overflow, bus84.sum} !== {1'b0, 1'b0, 8'h0C}) begin
        errors++; $display("FAIL add84 got lat=%0d co=%b ov=%b sum=%h exp lat=2 co=0 ov=0 sum=0C",
                          lat, bus84.carry_out, bus84.overflow, bus84.sum);
      end
    end
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = SUB_EN & 1'($urandom);
      model(8, a, b, cin, sub, s, co, ov);
      op84(a, b, cin, sub, lat);
      checks++;
      if (lat != 2 || bus84.sum !== 8'(s) || bus84.carry_out !== co || bus84.overflow !== ov) begin
        errors++;
        $display("FAIL rand84 a=%h b=%h cin=%b sub=%b got lat=%0d sum=%h co=%b ov=%b exp lat=2 sum=%h co=%b ov=%b",
                 a, b, cin, sub, lat, bus84.sum, bus84.carry_out, bus84.overflow, 8'(s), co, ov);
      end
    end
  endtask

  task automatic test_sweep4();
    int lat;
    int nsub;
    longint s;
    bit co, ov;
    nsub = SUB_EN ? 2 : 1;
    for (int sb = 0; sb < nsub; sb++)
      for (int ci = 0; ci < 2; ci++)
        for (int ai = 0; ai < 16; ai++)
          for (int bi = 0; bi < 16; bi++) begin
            model(4, longint'(ai), longint'(bi), ci[0], sb[0], s, co, ov);
            op4(4'(ai), 4'(bi), ci[0], sb[0], lat);
            checks++;
            if (lat != 4 || bus4.sum !== 4'(s) || bus4.carry_out !== co || bus4.overflow !== ov) begin
              errors++;
              $display("FAIL sweep4 a=%h b=%h cin=%0d sub=%0d got lat=%0d sum=%h co=%b ov=%b exp lat=4 sum=%h co=%b ov=%b",
                       ai, bi, ci, sb, lat, bus4.sum, bus4.carry_out, bus4.overflow, 4'(s), co, ov);
            end
          end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_chunk4();
    test_sweep4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
